// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
//
// Purpose:
//   Controls the scanning of an 8-digit display. A prescaler divides clk into
//   digit slots, and Scan steps through digits 0..7 once per slot. Host writes
//   go into shadow registers. All shadow registers are copied to the live
//   registers together at the end of a frame, so a frame never shows a mix of
//   old and new values.
//
// Optional feature:
//   DISP_BLINK_EN  - When defined, this adds an 8-bit blink mask and a blink
//                    phase. The phase toggles every BLINK_FRAMES frames. While
//                    the phase is high, the masked digits are forced blank.
//                    When undefined, mask writes are acknowledged and then
//                    dropped.
//
// Parameters:
//   SCAN_DIV      clk cycles per digit slot (2..65535)
//   BLINK_FRAMES  frames per blink half-period (1..255)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       write strobe, one write per cycle it is high
//   wr_sel      write target: 00 hex, 01 point, 10 LES, 11 blink mask
//   wr_data     write data; 8-bit targets take wr_data[7:0]
//   wr_ack      one-cycle pulse in the cycle after each write
//   Hexs        live digit nibbles
//   Scan        current digit index
//   point       live decimal-point bits
//   LES         live blank bits (1 = blanked), including blink masking
//   frame_tick  one-cycle pulse in the first cycle of each new frame
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic [31:0] Hexs,
  output logic [2:0]  Scan,
  output logic [7:0]  point,
  output logic [7:0]  LES,
  output logic        frame_tick
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [1:0]  SEL_HEX   = 2'b00;
  localparam logic [1:0]  SEL_POINT = 2'b01;
  localparam logic [1:0]  SEL_LES   = 2'b10;

  logic [15:0] presc;
  logic        slot_end;
  logic        frame_end;
  logic        pending;
  logic        commit;

  logic [31:0] hex_shadow;
  logic [7:0]  point_shadow;
  logic [7:0]  les_shadow;
  logic [31:0] hex_live;
  logic [7:0]  point_live;
  logic [7:0]  les_live;

  assign slot_end  = (presc == PRESC_MAX);
  assign frame_end = slot_end && (Scan == 3'd7);
  // A write in the commit cycle still sets pending again, so it is carried
  // into the next frame.
  assign commit    = frame_end && pending;

  // Slot/frame timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      Scan       <= '0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= slot_end ? '0 : presc + 16'd1;
      if (slot_end)
        Scan <= Scan + 3'd1;
      frame_tick <= frame_end;
    end
  end

  // Host write into shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack       <= 1'b0;
      pending      <= 1'b0;
      hex_shadow   <= '0;
      point_shadow <= '0;
      les_shadow   <= '0;
    end else begin
      wr_ack <= wr_en;
      if (wr_en)
        pending <= 1'b1;
      else if (commit)
        pending <= 1'b0;
      if (wr_en) begin
        case (wr_sel)
          SEL_HEX:   hex_shadow   <= wr_data;
          SEL_POINT: point_shadow <= wr_data[7:0];
          SEL_LES:   les_shadow   <= wr_data[7:0];
          default:   ;
        endcase
      end
    end
  end

  // Frame-boundary commit (uses the shadow values from before this edge)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_live   <= '0;
      point_live <= '0;
      les_live   <= '0;
    end else if (commit) begin
      hex_live   <= hex_shadow;
      point_live <= point_shadow;
      les_live   <= les_shadow;
    end
  end

  assign Hexs  = hex_live;
  assign point = point_live;

`ifdef DISP_BLINK_EN
  localparam logic [7:0] BLINK_MAX = 8'(BLINK_FRAMES - 1);

  logic [7:0] mask_shadow;
  logic [7:0] mask_live;
  logic [7:0] blink_cnt;
  logic       blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_shadow <= '0;
      mask_live   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (wr_en && (wr_sel == 2'b11))
        mask_shadow <= wr_data[7:0];
      if (commit)
        mask_live <= mask_shadow;
      if (frame_end) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

  assign LES = les_live | (mask_live & {8{blink_phase}});
`else
  assign LES = les_live;
`endif

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [31:0] Hexs;
  logic [2:0]  Scan;
  logic [7:0]  point;
  logic [7:0]  LES;
  logic        frame_tick;

  int n_cmp;
  int n_err;
  int cyc;

  disp_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_ack(wr_ack), .Hexs(Hexs), .Scan(Scan),
    .point(point), .LES(LES), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // cyc counts rising edges since the last reset release
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 2'b00; wr_data = '0;

    // Reset state
    repeat (3) tick();
    check("rst_scan", 32'(Scan), 32'd0);
    check("rst_hexs", Hexs, 32'd0);
    check("rst_point", 32'(point), 32'd0);
    check("rst_les", 32'(LES), 32'd0);
    check("rst_ack", 32'(wr_ack), 32'd0);
    check("rst_ftick", 32'(frame_tick), 32'd0);

    // First 33 edges after release: Scan steps every 4 clk, tick at edge 32
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      check("scan_step", 32'(Scan), 32'((k / 4) % 8));
      check("ftick_step", 32'(frame_tick), (k == 32) ? 32'd1 : 32'd0);
    end

    // Mid-frame hex write; commits at edge 64
    wr(2'b00, 32'h1234ABCD);
    tick();
    wr_en = 1'b0;
    check("hex_ack", 32'(wr_ack), 32'd1);
    check("hex_hold0", Hexs, 32'd0);
    tick();
    check("hex_ack_low", 32'(wr_ack), 32'd0);
    run_to(63);
    check("hex_before_fe", Hexs, 32'd0);
    tick();
    check("hex_commit", Hexs, 32'h1234ABCD);
    check("hex_ftick", 32'(frame_tick), 32'd1);

    // Pending hex write at edge 80, point write on the frame_end cycle (edge 96)
    run_to(79);
    wr(2'b00, 32'h0000_0055);
    tick();
    wr_en = 1'b0;
    run_to(95);
    wr(2'b01, 32'h0000_000F);
    tick();
    wr_en = 1'b0;
    check("fe_ack", 32'(wr_ack), 32'd1);
    check("fe_hex_commit", Hexs, 32'h0000_0055);
    check("fe_point_held", 32'(point), 32'h00);
    run_to(127);
    check("fe_point_mid", 32'(point), 32'h00);
    tick();
    check("fe_point_commit", 32'(point), 32'h0F);

    // Three back-to-back writes, all go live together at edge 160
    run_to(140);
    wr(2'b00, 32'hCAFEF00D);
    tick();
    check("b2b_ack0", 32'(wr_ack), 32'd1);
    wr(2'b01, 32'h0000_00AA);
    tick();
    check("b2b_ack1", 32'(wr_ack), 32'd1);
    wr(2'b10, 32'h0000_0080);
    tick();
    check("b2b_ack2", 32'(wr_ack), 32'd1);
    wr_en = 1'b0;
    tick();
    check("b2b_ack_low", 32'(wr_ack), 32'd0);
    run_to(159);
    check("b2b_hex_old", Hexs, 32'h0000_0055);
    check("b2b_point_old", 32'(point), 32'h0F);
    check("b2b_les_old", 32'(LES), 32'h00);
    tick();
    check("b2b_hex_new", Hexs, 32'hCAFEF00D);
    check("b2b_point_new", 32'(point), 32'hAA);
    check("b2b_les_new", 32'(LES), 32'h80);

    // Blink: LES 0 and mask 01 go live at edge 192. Phase toggles at the
    // frame ends 64, 128, 192, 256, 320, 384, so it is high from 192 to 255,
    // low from 256 to 319, high from 320 to 383, and low from 384 onward.
    run_to(165);
    wr(2'b10, 32'h0000_0000);
    tick();
    wr(2'b11, 32'h0000_0001);
    tick();
    wr_en = 1'b0;
    check("mask_ack", 32'(wr_ack), 32'd1);
    run_to(170);
    check("blink_pre", 32'(LES), 32'h80);
`ifdef DISP_BLINK_EN
    run_to(200); check("blink_on1", 32'(LES), 32'h01);
    run_to(260); check("blink_off1", 32'(LES), 32'h00);
    run_to(330); check("blink_on2", 32'(LES), 32'h01);
    run_to(390); check("blink_off2", 32'(LES), 32'h00);
`else
    run_to(200); check("noblink_a", 32'(LES), 32'h00);
    run_to(260); check("noblink_b", 32'(LES), 32'h00);
    run_to(330); check("noblink_c", 32'(LES), 32'h00);
    run_to(390); check("noblink_d", 32'(LES), 32'h00);
`endif

    // Asynchronous reset mid-frame with a pending write at Scan 5
    run_to(404);
    wr(2'b00, 32'hDEADBEEF);
    tick();
    wr_en = 1'b0;
    check("ar_scan5", 32'(Scan), 32'd5);
    check("ar_ack_pre", 32'(wr_ack), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_scan", 32'(Scan), 32'd0);
    check("ar_hexs", Hexs, 32'd0);
    check("ar_point", 32'(point), 32'd0);
    check("ar_les", 32'(LES), 32'd0);
    check("ar_ack", 32'(wr_ack), 32'd0);
    check("ar_ftick", 32'(frame_tick), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
    run_to(32);
    check("ar_ftick_fe", 32'(frame_tick), 32'd1);
    check("ar_nocommit_hex", Hexs, 32'd0);
    check("ar_nocommit_point", 32'(point), 32'd0);
    run_to(65);
    check("ar_nocommit_hex2", Hexs, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
